// File: rtl/ts_pkg.sv
// Shared constants, sync-FSM encoding and sizing helper for the TS transmit path.
package ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
   localparam int         TS_PACKET_SIZE = 188;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } ts_state_e;

   function automatic int bytes_per_word(input int width, input int byte_width = 8);
      return width / byte_width;
   endfunction

endpackage

// File: rtl/ts_byte_pacer.sv
// Inter-byte gap counter; a slot opens whenever the gap has expired and a byte is buffered.
module ts_byte_pacer #(
   parameter int GAP_CYCLES = 0
) (
   input  logic ts_clk,
   input  logic rst_n,
   input  logic buf_valid,
   output logic emit_slot,
   output logic gap_zero
);

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   logic [GW-1:0] gap_cnt_r;

   assign gap_zero  = (gap_cnt_r == GW'(0));
   assign emit_slot = gap_zero && buf_valid;

   // Reload the gap after each slot, then count down to the next opportunity.
   always_ff @(posedge ts_clk) begin
      if (!rst_n) begin
         gap_cnt_r <= GW'(0);
      end else if (emit_slot) begin
         gap_cnt_r <= GW'(GAP_CYCLES);
      end else if (!gap_zero) begin
         gap_cnt_r <= gap_cnt_r - GW'(1);
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

endmodule

// File: rtl/ts_word_serializer.sv
// Splits FIFO words into a paced TS byte stream, aligned on the packet sync byte.
module ts_word_serializer
   import ts_pkg::*;
#(
   parameter int                         MPEG_DATA_WIDTH      = 8,
   parameter int                         C_S_AXIS_TDATA_WIDTH = 32,
   parameter int                         PACKET_SIZE          = TS_PACKET_SIZE,
   parameter logic [MPEG_DATA_WIDTH-1:0] SYNC_BYTE            = TS_SYNC_BYTE,
   parameter int                         GAP_CYCLES           = 0
) (
   input  logic                            ts_clk,
   input  logic                            rst_n,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic                            ts_valid,
   output logic                            ts_sync,
   output logic [MPEG_DATA_WIDTH-1:0]      ts_data,
   output logic                            locked,
   output logic                            sync_error,
   output logic                            underflow
);

   localparam int N     = bytes_per_word(C_S_AXIS_TDATA_WIDTH, MPEG_DATA_WIDTH);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int POS_W = $clog2(PACKET_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(PACKET_SIZE - 1);

   logic [N-1:0][MPEG_DATA_WIDTH-1:0] buf_r;
   logic                              buf_valid_r;
   logic [IDX_W-1:0]                  byte_idx_r;
   logic [POS_W-1:0]                  pos_r;
   ts_state_e                         state_r;
   logic                              ts_valid_r, ts_sync_r, locked_r;
   logic                              sync_error_r, underflow_r, uf_seen_r;
   logic [MPEG_DATA_WIDTH-1:0]        ts_data_r;

   logic                              slot_s, gap_zero_s, accept_s, uf_cond_s;
   logic [MPEG_DATA_WIDTH-1:0]        cur_byte_s;

   ts_byte_pacer #(.GAP_CYCLES(GAP_CYCLES)) u_pacer (
      .ts_clk    (ts_clk),
      .rst_n     (rst_n),
      .buf_valid (buf_valid_r),
      .emit_slot (slot_s),
      .gap_zero  (gap_zero_s)
   );

   assign cur_byte_s = buf_r[byte_idx_r];
   assign in_ready   = !buf_valid_r || (slot_s && (byte_idx_r == LAST_IDX));
   assign accept_s   = in_valid && in_ready;
   assign uf_cond_s  = (state_r == LOCKED) && gap_zero_s && !buf_valid_r && (pos_r != POS_W'(0));

   assign ts_valid   = ts_valid_r;
   assign ts_sync    = ts_sync_r;
   assign ts_data    = ts_data_r;
   assign locked     = locked_r;
   assign sync_error = sync_error_r;
   assign underflow  = underflow_r;

   // Word buffer, sync FSM, packet position and all registered outputs.
   always_ff @(posedge ts_clk) begin
      if (!rst_n) begin
         buf_r        <= '{default: '0};
         buf_valid_r  <= 1'b0;
         byte_idx_r   <= IDX_W'(0);
         pos_r        <= POS_W'(0);
         state_r      <= HUNT;
         ts_valid_r   <= 1'b0;
         ts_sync_r    <= 1'b0;
         ts_data_r    <= MPEG_DATA_WIDTH'(0);
         locked_r     <= 1'b0;
         sync_error_r <= 1'b0;
         underflow_r  <= 1'b0;
         uf_seen_r    <= 1'b0;
      end else begin
         ts_valid_r   <= 1'b0;
         ts_sync_r    <= 1'b0;
         sync_error_r <= 1'b0;
         // One pulse per starvation episode; re-armed once data is buffered again.
         underflow_r  <= uf_cond_s && !uf_seen_r;
         uf_seen_r    <= buf_valid_r ? 1'b0 : (uf_seen_r || uf_cond_s);

         if (accept_s) begin
            buf_r       <= in_data;
            buf_valid_r <= 1'b1;
            byte_idx_r  <= IDX_W'(0);
         end else if (slot_s && (byte_idx_r == LAST_IDX)) begin
            buf_valid_r <= 1'b0;
            byte_idx_r  <= IDX_W'(0);
         end else if (slot_s) begin
            byte_idx_r  <= byte_idx_r + IDX_W'(1);
         end else begin
            byte_idx_r  <= byte_idx_r;
         end

         if (slot_s) begin
            case (state_r)
               HUNT: begin
                  if (cur_byte_s == SYNC_BYTE) begin
                     ts_valid_r <= 1'b1;
                     ts_sync_r  <= 1'b1;
                     ts_data_r  <= cur_byte_s;
                     pos_r      <= POS_W'(1);
                     state_r    <= LOCKED;
                     locked_r   <= 1'b1;
                  end else begin
                     state_r    <= HUNT;
                  end
               end
               LOCKED: begin
                  if ((pos_r == POS_W'(0)) && (cur_byte_s != SYNC_BYTE)) begin
                     sync_error_r <= 1'b1;
                     state_r      <= HUNT;
                     locked_r     <= 1'b0;
                  end else begin
                     ts_valid_r <= 1'b1;
                     ts_sync_r  <= (pos_r == POS_W'(0));
                     ts_data_r  <= cur_byte_s;
                     pos_r      <= (pos_r == LAST_POS) ? POS_W'(0) : pos_r + POS_W'(1);
                  end
               end
               default: begin
                  state_r  <= HUNT;
                  locked_r <= 1'b0;
               end
            endcase
         end else begin
            pos_r <= pos_r;
         end
      end
   end

endmodule

// File: tb/tb_ts_word_serializer.sv
// Randomized self-checking bench for ts_word_serializer against a packet-level reference model.
module tb_ts_word_serializer;

   logic        ts_clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data0, in_data1;
   logic        in_valid0, in_valid1;
   logic        in_ready0, in_ready1;
   logic        ts_valid0, ts_valid1, ts_sync0, ts_sync1;
   logic [7:0]  ts_data0, ts_data1;
   logic        locked0, locked1, sync_error0, sync_error1, underflow0, underflow1;

   always #5 ts_clk = ~ts_clk;

   ts_word_serializer #(.GAP_CYCLES(0)) dut0 (
      .ts_clk(ts_clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
      .in_ready(in_ready0), .ts_valid(ts_valid0), .ts_sync(ts_sync0), .ts_data(ts_data0),
      .locked(locked0), .sync_error(sync_error0), .underflow(underflow0)
   );

   ts_word_serializer #(.GAP_CYCLES(3)) dut1 (
      .ts_clk(ts_clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .ts_valid(ts_valid1), .ts_sync(ts_sync1), .ts_data(ts_data1),
      .locked(locked1), .sync_error(sync_error1), .underflow(underflow1)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [8:0] obs0_q[$], obs1_q[$], exp_q[$];
   int         obs0_cyc[$], obs1_cyc[$], acc_q[$];
   int         serr0, uf0, bad0, lock_cyc0, serr1, uf1;
   int         exp_err;
   logic       locked0_d = 1'b0;

   always @(posedge ts_clk) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle.
   always @(negedge ts_clk) begin
      if (ts_valid0) begin
         obs0_q.push_back({ts_sync0, ts_data0});
         obs0_cyc.push_back(cyc);
      end
      if (ts_valid1) begin
         obs1_q.push_back({ts_sync1, ts_data1});
         obs1_cyc.push_back(cyc);
      end
      if (sync_error0) serr0++;
      if (underflow0) uf0++;
      if (sync_error1) serr1++;
      if (underflow1) uf1++;
      if ((ts_sync0 && !ts_valid0) || (sync_error0 && locked0)) bad0++;
      if (locked0 && !locked0_d) lock_cyc0 = cyc;
      locked0_d = locked0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Packet-level reference: find a sync byte, pass whole packets, and at each
   // packet boundary either continue on a sync byte or count an error and re-hunt.
   task automatic build_expected(input logic [7:0] bq[$]);
      int k;
      bit at_boundary;
      k = 0;
      at_boundary = 1'b0;
      exp_q = {};
      exp_err = 0;
      while (k < bq.size()) begin
         if (bq[k] != 8'h47) begin
            if (at_boundary) exp_err++;
            at_boundary = 1'b0;
            k++;
         end else begin
            for (int j = 0; j < 188 && k + j < bq.size(); j++)
               exp_q.push_back({(j == 0), bq[k + j]});
            k += 188;
            at_boundary = 1'b1;
         end
      end
   endtask

   function automatic logic [7:0] rnd_non_sync();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h47) b = 8'h48;
      return b;
   endfunction

   task automatic add_packet(inout logic [7:0] bq[$]);
      bq.push_back(8'h47);
      for (int i = 1; i < 188; i++) bq.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic tick();
      @(posedge ts_clk);
      #1;
   endtask

   task automatic clear_obs();
      obs0_q = {}; obs1_q = {}; obs0_cyc = {}; obs1_cyc = {}; acc_q = {};
      serr0 = 0; uf0 = 0; bad0 = 0; lock_cyc0 = -1; serr1 = 0; uf1 = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      in_data0 = 32'h0; in_data1 = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      clear_obs();
   endtask

   task automatic put_word(input int sel, input logic [31:0] w);
      logic r;
      int   n;
      if (sel == 0) begin in_data0 = w; in_valid0 = 1'b1; end
      else          begin in_data1 = w; in_valid1 = 1'b1; end
      r = 1'b0;
      n = 0;
      while (!r && n < 200) begin
         @(negedge ts_clk);
         r = (sel == 0) ? in_ready0 : in_ready1;
         tick();
         n++;
      end
      checks++;
      if (!r) begin
         errors++;
         $display("FAIL put_word_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end else begin
         acc_q.push_back(cyc);
      end
   endtask

   // Sends bytes as little-endian words; before word pause_word in_valid drops for 5 accept cycles.
   task automatic send_bytes(input int sel, input logic [7:0] bq[$], input int pause_word);
      for (int i = 0; i < bq.size() / 4; i++) begin
         if (i == pause_word) begin
            if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
            for (int n = 0; n < 100; n++) begin
               @(negedge ts_clk);
               if (((sel == 0) ? in_ready0 : in_ready1) == 1'b1) break;
            end
            tick();
            repeat (4) tick();
         end
         put_word(sel, {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]});
      end
      if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] bq[$];
      do_reset();
      @(negedge ts_clk);
      checks++; if (ts_valid0 !== 1'b0)   begin errors++; $display("FAIL reset_ts_valid: got %b want 0", ts_valid0); end
      checks++; if (ts_sync0 !== 1'b0)    begin errors++; $display("FAIL reset_ts_sync: got %b want 0", ts_sync0); end
      checks++; if (ts_data0 !== 8'h00)   begin errors++; $display("FAIL reset_ts_data: got %h want 00", ts_data0); end
      checks++; if (locked0 !== 1'b0)     begin errors++; $display("FAIL reset_locked: got %b want 0", locked0); end
      checks++; if (sync_error0 !== 1'b0) begin errors++; $display("FAIL reset_sync_error: got %b want 0", sync_error0); end
      checks++; if (underflow0 !== 1'b0)  begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow0); end
      checks++; if (in_ready0 !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
      checks++; if (locked1 !== 1'b0)     begin errors++; $display("FAIL reset_locked_gap: got %b want 0", locked1); end
      tick();
      for (int i = 0; i < 8; i++) bq.push_back(rnd_non_sync());
      send_bytes(0, bq, -1);
      repeat (8) tick();
      checks++; if (obs0_q.size() != 0) begin errors++; $display("FAIL hunt_discard: got %0d bytes want 0", obs0_q.size()); end
      checks++; if (locked0 !== 1'b0)   begin errors++; $display("FAIL hunt_locked: got %b want 0", locked0); end
   endtask

   task automatic test_aligned();
      logic [7:0] bq[$];
      int bad_gap, nsync;
      do_reset();
      bq.push_back(8'h47);
      for (int i = 1; i < 188; i++) bq.push_back(8'(i));
      send_bytes(0, bq, -1);
      repeat (10) tick();
      build_expected(bq);
      checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL aligned_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
      for (int i = 0; i < obs0_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL aligned_byte[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
      end
      nsync = 0;
      foreach (obs0_q[i]) if (obs0_q[i][8]) nsync++;
      checks++; if (nsync != 1) begin errors++; $display("FAIL aligned_sync_count: got %0d want 1", nsync); end
      if (obs0_cyc.size() == 188 && acc_q.size() == 47) begin
         checks++; if (obs0_cyc[187] - obs0_cyc[0] != 187) begin errors++; $display("FAIL aligned_contiguous: span %0d want 187", obs0_cyc[187] - obs0_cyc[0]); end
         checks++; if (obs0_cyc[0] != acc_q[0] + 1) begin errors++; $display("FAIL aligned_latency: got %0d want %0d", obs0_cyc[0] - acc_q[0], 1); end
         checks++; if (lock_cyc0 != obs0_cyc[0]) begin errors++; $display("FAIL aligned_lock_rise: cycle %0d want %0d", lock_cyc0, obs0_cyc[0]); end
         bad_gap = 0;
         for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 4) bad_gap++;
         checks++; if (bad_gap != 0) begin errors++; $display("FAIL aligned_word_rate: %0d gaps not 4 cycles, want 0", bad_gap); end
      end
      checks++; if (bad0 != 0) begin errors++; $display("FAIL aligned_protocol: %0d bad cycles want 0", bad0); end
   endtask

   task automatic test_misaligned();
      logic [7:0] bq[$];
      do_reset();
      bq = '{8'h22, 8'h11, 8'h00};
      add_packet(bq);
      bq.push_back(rnd_non_sync());
      send_bytes(0, bq, -1);
      repeat (10) tick();
      build_expected(bq);
      checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL misalign_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
      for (int i = 0; i < obs0_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL misalign_byte[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
      end
      checks++; if (serr0 != exp_err) begin errors++; $display("FAIL misalign_sync_error: got %0d want %0d", serr0, exp_err); end
   endtask

   task automatic test_lost_sync();
      logic [7:0] bq[$];
      do_reset();
      add_packet(bq);
      bq.push_back(8'h00);
      for (int i = 0; i < 3; i++) bq.push_back(rnd_non_sync());
      add_packet(bq);
      send_bytes(0, bq, -1);
      repeat (10) tick();
      build_expected(bq);
      checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL lost_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
      for (int i = 0; i < obs0_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL lost_byte[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
      end
      checks++; if (serr0 != exp_err) begin errors++; $display("FAIL lost_sync_error: got %0d want %0d", serr0, exp_err); end
      checks++; if (bad0 != 0)        begin errors++; $display("FAIL lost_locked_drop: %0d bad cycles want 0", bad0); end
      checks++; if (locked0 !== 1'b1) begin errors++; $display("FAIL lost_relock: got %b want 1", locked0); end
   endtask

   task automatic test_underflow();
      logic [7:0] bq[$];
      do_reset();
      add_packet(bq);
      add_packet(bq);
      send_bytes(0, bq, 25);
      repeat (10) tick();
      build_expected(bq);
      checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL uf_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
      for (int i = 0; i < obs0_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL uf_byte[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
      end
      checks++; if (uf0 != 1) begin errors++; $display("FAIL uf_pulses: got %0d want 1", uf0); end
      checks++; if (serr0 != 0) begin errors++; $display("FAIL uf_sync_error: got %0d want 0", serr0); end
      if (obs0_cyc.size() > 188) begin
         checks++; if (obs0_cyc[100] - obs0_cyc[99] != 6) begin errors++; $display("FAIL uf_gap: got %0d idle cycles want 5", obs0_cyc[100] - obs0_cyc[99] - 1); end
         checks++; if (obs0_q[188][8] !== 1'b1) begin errors++; $display("FAIL uf_next_sync: got %b want 1", obs0_q[188][8]); end
      end
   endtask

   task automatic test_pacing();
      logic [7:0] bq[$];
      int bad_gap, bad_acc;
      do_reset();
      add_packet(bq);
      send_bytes(1, bq, -1);
      repeat (30) tick();
      build_expected(bq);
      checks++; if (obs1_q.size() != exp_q.size()) begin errors++; $display("FAIL pace_count: got %0d want %0d", obs1_q.size(), exp_q.size()); end
      for (int i = 0; i < obs1_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs1_q[i] !== exp_q[i]) begin errors++; $display("FAIL pace_byte[%0d]: got %h want %h", i, obs1_q[i], exp_q[i]); end
      end
      bad_gap = 0;
      for (int i = 1; i < obs1_cyc.size(); i++) if (obs1_cyc[i] - obs1_cyc[i-1] != 4) bad_gap++;
      checks++; if (bad_gap != 0) begin errors++; $display("FAIL pace_byte_rate: %0d gaps not 4 cycles, want 0", bad_gap); end
      bad_acc = 0;
      for (int i = 2; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 16) bad_acc++;
      checks++; if (bad_acc != 0 || acc_q.size() != 47) begin errors++; $display("FAIL pace_word_rate: %0d bad of %0d words, want 0 of 47", bad_acc, acc_q.size()); end
      checks++; if (uf1 != 0 || serr1 != 0) begin errors++; $display("FAIL pace_pulses: uf %0d serr %0d want 0 0", uf1, serr1); end
   endtask

   task automatic test_mid_reset();
      logic [7:0] bq[$], bq2[$];
      do_reset();
      add_packet(bq);
      bq = bq[0:51];
      send_bytes(0, bq, -1);
      for (int n = 0; n < 100; n++) begin
         @(negedge ts_clk);
         if (obs0_q.size() >= 50) break;
      end
      rst_n = 1'b0;
      @(posedge ts_clk);
      @(negedge ts_clk);
      checks++; if ({ts_valid0, ts_sync0, ts_data0, sync_error0, underflow0} !== 12'h000)
         begin errors++; $display("FAIL midrst_outputs: got %h want 000", {ts_valid0, ts_sync0, ts_data0, sync_error0, underflow0}); end
      checks++; if (locked0 !== 1'b0)  begin errors++; $display("FAIL midrst_locked: got %b want 0", locked0); end
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL midrst_buffer: in_ready %b want 1", in_ready0); end
      rst_n = 1'b1;
      tick();
      clear_obs();
      for (int i = 0; i < 4; i++) bq2.push_back(rnd_non_sync());
      add_packet(bq2);
      send_bytes(0, bq2, -1);
      repeat (10) tick();
      build_expected(bq2);
      checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
      for (int i = 0; i < obs0_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_misaligned();
      test_lost_sync();
      test_underflow();
      test_pacing();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
